// File: rtl/rn_pkg.sv
// Shared constants, FSM state type and popcount helper for the rename free-list allocator.
package rn_pkg;

    localparam int NPHYS = 64;
    localparam int NARCH = 32;
    localparam int TAGW  = $clog2(NPHYS);
    localparam int DEPTH = NPHYS - NARCH;
    localparam int IDXW  = $clog2(DEPTH);
    localparam int PTRW  = IDXW + 1;

    typedef enum logic [1:0] {
        FL_INIT,
        FL_RUN,
        FL_RECOVER
    } fl_state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/fl_compact4.sv
// Prefix-count generator: slot k's offset is the number of set bits below it.
module fl_compact4
    import rn_pkg::*;
(
    input  logic [3:0]      valid_i,
    output logic [3:0][2:0] off_o,
    output logic [2:0]      total_o
);

    always_comb begin
        off_o[0] = 3'd0;
        off_o[1] = 3'(valid_i[0]);
        off_o[2] = 3'(valid_i[0]) + 3'(valid_i[1]);
        off_o[3] = popcount4({1'b0, valid_i[2:0]});
    end

    assign total_o = popcount4(valid_i);

endmodule

// File: rtl/rn_freelist_ctrl.sv
// Physical-register free list and rename stall controller (4-wide alloc/release).
// Optional occupancy checking is enabled by defining FREELIST_CHECK_EN.
module rn_freelist_ctrl
    import rn_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [3:0]      alloc_req,
    output logic [TAGW-1:0] alloc_tag1,
    output logic [TAGW-1:0] alloc_tag2,
    output logic [TAGW-1:0] alloc_tag3,
    output logic [TAGW-1:0] alloc_tag4,
    output logic            Stall,
    input  logic [3:0]      rel_valid,
    input  logic [TAGW-1:0] rel_tag1,
    input  logic [TAGW-1:0] rel_tag2,
    input  logic [TAGW-1:0] rel_tag3,
    input  logic [TAGW-1:0] rel_tag4,
    input  logic [2:0]      commit_alloc,
    output logic [6:0]      free_count,
    output logic            fl_ready,
    output logic            fl_err
);

    fl_state_e       state_q, state_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [PTRW-1:0] spec_head_q, spec_head_d;
    logic [PTRW-1:0] cmt_head_q, cmt_head_d;
    logic [2:0]      init_cnt_q;
    logic [TAGW-1:0] mem_q [DEPTH];

    logic [TAGW-1:0] rel_tag   [4];
    logic [TAGW-1:0] alloc_tag [4];
    logic [IDXW-1:0] alloc_idx [4];
    logic [IDXW-1:0] rel_idx   [4];
    logic [IDXW-1:0] init_idx  [4];
    logic [3:0][2:0] aoff, roff;
    logic [2:0]      an, rn;
    logic [PTRW-1:0] fc;
    logic            active, rel_ok, cmt_ok;

    assign rel_tag[0] = rel_tag1;
    assign rel_tag[1] = rel_tag2;
    assign rel_tag[2] = rel_tag3;
    assign rel_tag[3] = rel_tag4;

    fl_compact4 u_alloc_off (.valid_i(alloc_req), .off_o(aoff), .total_o(an));
    fl_compact4 u_rel_off   (.valid_i(rel_valid), .off_o(roff), .total_o(rn));

    assign fc         = tail_q - spec_head_q;
    assign free_count = 7'(fc);
    assign active     = (state_q != FL_INIT);
    assign fl_ready   = active;
    // All-or-nothing grant: any shortfall stalls the whole rename group.
    assign Stall      = (state_q != FL_RUN) || flush || (PTRW'(an) > fc);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            alloc_idx[k] = IDXW'(spec_head_q + PTRW'(aoff[k]));
            rel_idx[k]   = IDXW'(tail_q + PTRW'(roff[k]));
            init_idx[k]  = IDXW'(tail_q + PTRW'(k));
            alloc_tag[k] = (!Stall && alloc_req[k]) ? mem_q[alloc_idx[k]] : '0;
        end
    end

    assign alloc_tag1 = alloc_tag[0];
    assign alloc_tag2 = alloc_tag[1];
    assign alloc_tag3 = alloc_tag[2];
    assign alloc_tag4 = alloc_tag[3];

`ifdef FREELIST_CHECK_EN
    logic err_q;
    logic low_tag;

    always_comb begin
        low_tag = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rel_valid[k] && (rel_tag[k] < TAGW'(NARCH))) low_tag = 1'b1;
        end
        rel_ok = !low_tag && (({1'b0, tail_q - cmt_head_q} + (PTRW+1)'(rn)) <= (PTRW+1)'(DEPTH));
        cmt_ok = (PTRW'(commit_alloc) <= (spec_head_q - cmt_head_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (active && (!rel_ok || !cmt_ok)) begin
            err_q <= 1'b1;
        end
    end

    assign fl_err = err_q;
`else
    assign rel_ok = 1'b1;
    assign cmt_ok = 1'b1;
    assign fl_err = 1'b0;
`endif

    // NOTE: next-state logic uses blocking assignments with defaults first; only always_ff uses <=.
    always_comb begin
        state_d     = state_q;
        tail_d      = tail_q;
        spec_head_d = spec_head_q;
        cmt_head_d  = cmt_head_q;
        case (state_q)
            FL_INIT: begin
                tail_d = tail_q + PTRW'(4);
                if (init_cnt_q == 3'(DEPTH / 4 - 1)) state_d = FL_RUN;
            end
            default: begin
                if (rel_ok) tail_d = tail_q + PTRW'(rn);
                if (cmt_ok) cmt_head_d = cmt_head_q + PTRW'(commit_alloc);
                if (flush) begin
                    spec_head_d = cmt_head_d;
                    state_d     = FL_RECOVER;
                end else begin
                    if (!Stall) spec_head_d = spec_head_q + PTRW'(an);
                    state_d = FL_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FL_INIT;
            tail_q      <= '0;
            spec_head_q <= '0;
            cmt_head_q  <= '0;
            init_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tail_q      <= tail_d;
            spec_head_q <= spec_head_d;
            cmt_head_q  <= cmt_head_d;
            init_cnt_q  <= (state_q == FL_INIT) ? init_cnt_q + 3'd1 : 3'd0;
        end
    end

    // NOTE: the tag array is deliberately not reset; INIT rewrites every entry before any read.
    always_ff @(posedge clk) begin
        if (state_q == FL_INIT) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[init_idx[k]] <= TAGW'(NARCH + 4 * int'(init_cnt_q) + k);
            end
        end else if (rel_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (rel_valid[k]) mem_q[rel_idx[k]] <= rel_tag[k];
            end
        end
    end

endmodule

// File: tb/tb_rn_freelist_ctrl.sv
// Directed plus randomized bench for rn_freelist_ctrl against a queue-based free-list model.
module tb_rn_freelist_ctrl;
    import rn_pkg::*;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic [3:0]      alloc_req, rel_valid;
    logic [TAGW-1:0] alloc_tag1, alloc_tag2, alloc_tag3, alloc_tag4;
    logic [TAGW-1:0] rel_tag1, rel_tag2, rel_tag3, rel_tag4;
    logic            Stall, fl_ready, fl_err;
    logic [2:0]      commit_alloc;
    logic [6:0]      free_count;

    always #5 clk = ~clk;

    rn_freelist_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .alloc_req(alloc_req),
        .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
        .alloc_tag3(alloc_tag3), .alloc_tag4(alloc_tag4),
        .Stall(Stall), .rel_valid(rel_valid),
        .rel_tag1(rel_tag1), .rel_tag2(rel_tag2), .rel_tag3(rel_tag3), .rel_tag4(rel_tag4),
        .commit_alloc(commit_alloc), .free_count(free_count),
        .fl_ready(fl_ready), .fl_err(fl_err)
    );

`ifdef FREELIST_CHECK_EN
    localparam int REL_T = 45;
`else
    localparam int REL_T = 5;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: fl holds every entry from the committed point to the tail, in order;
    // the first spec_n of them are speculatively allocated.
    int fl [$];
    int spec_n;
    bit m_run;
    bit m_err;

    int   obs_tag [4];
    logic obs_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; alloc_req = '0; rel_valid = '0; commit_alloc = '0;
        rel_tag1 = '0; rel_tag2 = '0; rel_tag3 = '0; rel_tag4 = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_free_count", 32'(free_count), 0);
        check("rst_fl_err", 32'(fl_err), 0);
        check("rst_tag1", 32'(alloc_tag1), 0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(negedge clk);
                // Flush and releases during INIT must be ignored.
                flush = (i == 3);
                rel_valid = (i == 4) ? 4'b1111 : 4'b0000;
                rel_tag1 = TAGW'(40);
                alloc_req = 4'b0001;
                #1;
            end
            check("init_stall", 32'(Stall), 1);
            check("init_ready", 32'(fl_ready), 0);
        end
        flush = 1'b0; rel_valid = '0; alloc_req = '0;
        fl.delete();
        for (int t = NARCH; t < NPHYS; t++) fl.push_back(t);
        spec_n = 0;
        m_run  = 1'b1;
        m_err  = 1'b0;
    endtask

    task automatic cycle(input logic [3:0] req, input logic [3:0] rv,
                         input logic [3:0][TAGW-1:0] rt, input int cmt, input logic fls);
        int   n, avail, k, spec_pre, npop;
        logic stall_e, rel_legal;
        int   tag_e [4];
        @(negedge clk);
        alloc_req = req; rel_valid = rv; commit_alloc = 3'(cmt); flush = fls;
        rel_tag1 = rt[0]; rel_tag2 = rt[1]; rel_tag3 = rt[2]; rel_tag4 = rt[3];
        #1;
        n       = $countones(req);
        avail   = fl.size() - spec_n;
        stall_e = !m_run || fls || (n > avail);
        k       = spec_n;
        for (int i = 0; i < 4; i++) begin
            tag_e[i] = 0;
            if (!stall_e && req[i]) begin
                tag_e[i] = fl[k];
                k++;
            end
        end
        check("stall", 32'(Stall), 32'(stall_e));
        check("free_count", 32'(free_count), 32'(avail));
        check("fl_ready", 32'(fl_ready), 1);
        check("fl_err", 32'(fl_err), 32'(m_err));
        check("tag1", 32'(alloc_tag1), 32'(tag_e[0]));
        check("tag2", 32'(alloc_tag2), 32'(tag_e[1]));
        check("tag3", 32'(alloc_tag3), 32'(tag_e[2]));
        check("tag4", 32'(alloc_tag4), 32'(tag_e[3]));
        obs_tag[0] = int'(alloc_tag1); obs_tag[1] = int'(alloc_tag2);
        obs_tag[2] = int'(alloc_tag3); obs_tag[3] = int'(alloc_tag4);
        obs_stall  = Stall;
        @(posedge clk);
        spec_pre  = spec_n;
        npop      = $countones(rv);
        rel_legal = 1'b1;
`ifdef FREELIST_CHECK_EN
        if (fl.size() + npop > DEPTH) rel_legal = 1'b0;
        for (int i = 0; i < 4; i++) if (rv[i] && int'(rt[i]) < NARCH) rel_legal = 1'b0;
        if (!rel_legal) m_err = 1'b1;
        if (cmt > spec_pre) begin
            m_err = 1'b1;
            cmt   = 0;
        end
`endif
        if (!stall_e) spec_n = k;
        for (int j = 0; j < cmt; j++) void'(fl.pop_front());
        spec_n = spec_n - cmt;
        if (fls) spec_n = 0;
        m_run = !fls;
        if (rel_legal) for (int i = 0; i < 4; i++) if (rv[i]) fl.push_back(int'(rt[i]));
    endtask

    initial begin
        logic [3:0][TAGW-1:0] rt;
        logic [3:0]           req, rv;
        int                   cmt;
        logic                 fls;
        rt = '0;

        // 1-2: init, then a sparse 4-wide request
        do_reset();
        cycle(4'b1011, 4'b0000, rt, 0, 1'b0);
        check("t2_tag1", 32'(obs_tag[0]), 32);
        check("t2_tag2", 32'(obs_tag[1]), 33);
        check("t2_tag3", 32'(obs_tag[2]), 0);
        check("t2_tag4", 32'(obs_tag[3]), 34);
        #1 check("t2_free", 32'(free_count), 29);

        // 3: exhaust, stall on empty, then recycle a released tag
        do_reset();
        repeat (8) cycle(4'b1111, 4'b0000, rt, 0, 1'b0);
        #1 check("t3_free_empty", 32'(free_count), 0);
        cycle(4'b0001, 4'b0000, rt, 0, 1'b0);
        check("t3_stall_empty", 32'(obs_stall), 1);
        check("t3_tag_empty", 32'(obs_tag[0]), 0);
        repeat (8) cycle(4'b0000, 4'b0000, rt, 4, 1'b0);
        rt[0] = TAGW'(REL_T);
        cycle(4'b0000, 4'b0001, rt, 0, 1'b0);
        cycle(4'b0001, 4'b0000, rt, 0, 1'b0);
        check("t3_recycled", 32'(obs_tag[0]), 32'(REL_T));
        check("t3_stall_grant", 32'(obs_stall), 0);

        // 4: flush with same-cycle commit, RECOVER stall, rollback reuse
        do_reset();
        repeat (3) cycle(4'b1111, 4'b0000, rt, 0, 1'b0);
        cycle(4'b0000, 4'b0000, rt, 4, 1'b1);
        #1 check("t4_free", 32'(free_count), 28);
        cycle(4'b0001, 4'b0000, rt, 0, 1'b0);
        check("t4_recover_stall", 32'(obs_stall), 1);
        cycle(4'b0001, 4'b0000, rt, 0, 1'b0);
        check("t4_reuse", 32'(obs_tag[0]), 36);

        // 5: simultaneous allocate 2 / release 3 at free_count 10
        repeat (4) cycle(4'b1111, 4'b0000, rt, 0, 1'b0);
        cycle(4'b0001, 4'b0000, rt, 0, 1'b0);
        #1 check("t5_free_before", 32'(free_count), 10);
        rt[0] = TAGW'(50); rt[1] = TAGW'(51); rt[2] = TAGW'(52);
        cycle(4'b0011, 4'b0111, rt, 0, 1'b0);
        check("t5_no_bypass", 32'(obs_tag[0] >= 50 && obs_tag[0] <= 52), 0);
        #1 check("t5_free_after", 32'(free_count), 11);

        // 6: release into a full list
        do_reset();
        rt[0] = TAGW'(40);
        cycle(4'b0000, 4'b0001, rt, 0, 1'b0);
`ifdef FREELIST_CHECK_EN
        #1 check("t6_err", 32'(fl_err), 1);
        check("t6_free", 32'(free_count), 32);
`else
        #1 check("t6_err", 32'(fl_err), 0);
        check("t6_free", 32'(free_count), 33);
`endif
        cycle(4'b0000, 4'b0000, rt, 0, 1'b0);

        // Randomized legal traffic
        do_reset();
        for (int it = 0; it < 400; it++) begin
            req = 4'($urandom);
            rv  = ($urandom_range(2, 0) == 0) ? 4'($urandom) : 4'b0000;
            while (fl.size() + $countones(rv) > DEPTH) rv = 4'(rv & (rv - 4'd1));
            for (int i = 0; i < 4; i++) rt[i] = TAGW'($urandom_range(NPHYS - 1, NARCH));
            cmt = $urandom_range(4, 0);
            if (cmt > spec_n) cmt = spec_n;
            fls = ($urandom_range(15, 0) == 0);
            cycle(req, rv, rt, cmt, fls);
        end

        // Reset mid-operation re-enters INIT
        do_reset();
        cycle(4'b0001, 4'b0000, rt, 0, 1'b0);
        check("final_tag", 32'(obs_tag[0]), 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
